// File: rtl/mul_pkg.sv
// Shared constants and helpers for the dual-lane unsigned array multiplier.
package mul_pkg;

  localparam int MUL_MIN_W = 1;
  localparam int MUL_MAX_W = 16;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/mul_lane.sv
// Combinational WIDTH x WIDTH unsigned array multiplier: shifted partial
// products accumulated row by row through ripple-carry adders.
module mul_lane
  import mul_pkg::*;
#(
  parameter  int WIDTH = 1,
  localparam int PW    = prod_width(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [PW-1:0]    p
);

  logic [PW-1:0] pp  [WIDTH];
  logic [PW-1:0] acc [WIDTH];

  // The carry out of the top bit is always zero since (2^W-1)^2 fits in PW bits.
  function automatic logic [PW-1:0] ripple_add(input logic [PW-1:0] s0,
                                               input logic [PW-1:0] s1);
    logic          cy;
    logic [PW-1:0] sum;
    cy  = 1'b0;
    sum = '0;
    for (int k = 0; k < PW; k++) begin
      sum[k] = s0[k] ^ s1[k] ^ cy;
      cy     = (s0[k] & s1[k]) | (cy & (s0[k] ^ s1[k]));
    end
    return sum;
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    assign pp[i] = {{WIDTH{1'b0}}, (y[i] ? x : {WIDTH{1'b0}})} << i;
  end

  assign acc[0] = pp[0];

  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    assign acc[i] = ripple_add(acc[i-1], pp[i]);
  end

  assign p = acc[WIDTH-1];

endmodule

// File: rtl/multiplier.sv
// Dual-lane unsigned multiplier: e = a*b, f = c*d, registered with one cycle
// of latency and cleared asynchronously while reset is low.
module multiplier
  import mul_pkg::*;
#(
  parameter  int WIDTH = 1,
  localparam int PW    = prod_width(WIDTH)
) (
  output logic [PW-1:0]    e,
  output logic [PW-1:0]    f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic             clk,
  input  logic             reset
);

  if (WIDTH < MUL_MIN_W || WIDTH > MUL_MAX_W) begin : g_bad_width
    $error("multiplier: WIDTH out of legal range");
  end

  logic [PW-1:0] prod0;
  logic [PW-1:0] prod1;

  mul_lane #(.WIDTH(WIDTH)) u_lane0 (
    .x (a),
    .y (b),
    .p (prod0)
  );

  mul_lane #(.WIDTH(WIDTH)) u_lane1 (
    .x (c),
    .y (d),
    .p (prod1)
  );

  // reset is active-low: a low level clears both products without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e <= '0;
      f <= '0;
    end else begin
      e <= prod0;
      f <= prod1;
    end
  end

endmodule

// File: tb/tb_multiplier.sv
// Directed self-checking bench for multiplier at WIDTH=1 and WIDTH=4.
module tb_multiplier;

  logic       clk;
  logic       reset;
  logic       a1, b1, c1, d1;
  logic [1:0] e1, f1;
  logic [3:0] a4, b4, c4, d4;
  logic [7:0] e4, f4;

  int compared   = 0;
  int mismatched = 0;

  multiplier #(.WIDTH(1)) dut1 (
    .e(e1), .f(f1), .a(a1), .b(b1), .c(c1), .d(d1), .clk(clk), .reset(reset)
  );

  multiplier #(.WIDTH(4)) dut4 (
    .e(e4), .f(f4), .a(a4), .b(b4), .c(c4), .d(d4), .clk(clk), .reset(reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] na, input logic [3:0] nb,
                               input logic [3:0] nc, input logic [3:0] nd,
                               input bit wide);
    if (wide) begin
      a4 = na; b4 = nb; c4 = nc; d4 = nd;
    end else begin
      a1 = na[0]; b1 = nb[0]; c1 = nc[0]; d1 = nd[0];
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    logic [1:0] ttA [4];
    logic [1:0] ttB [4];
    logic [1:0] ttE [4];
    ttA = '{2'd0, 2'd0, 2'd1, 2'd1};
    ttB = '{2'd0, 2'd1, 2'd0, 2'd1};
    ttE = '{2'd0, 2'd0, 2'd0, 2'd1};

    reset = 1'b0;
    applyStimulus(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    applyStimulus(4'd3, 4'd5, 4'd7, 4'd9, 1'b1);

    // Outputs must stay cleared while reset is held low and the clock runs.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("reset_hold_e1", 32'(e1), 32'd0);
      checkOutput("reset_hold_f1", 32'(f1), 32'd0);
      checkOutput("reset_hold_e4", 32'(e4), 32'd0);
      checkOutput("reset_hold_f4", 32'(f4), 32'd0);
    end

    @(negedge clk);
    reset = 1'b1;
    tick();
    checkOutput("first_capture_e1", 32'(e1), 32'd1);
    checkOutput("first_capture_f1", 32'(f1), 32'd1);
    checkOutput("first_capture_e4", 32'(e4), 32'd15);
    checkOutput("first_capture_f4", 32'(f4), 32'd63);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'(ttA[i]), 4'(ttB[i]), 4'd1, 4'd1, 1'b0);
      tick();
      checkOutput($sformatf("truth_e1_%0d", i), 32'(e1), 32'(ttE[i]));
      checkOutput($sformatf("truth_f1_%0d", i), 32'(f1), 32'd1);
    end

    applyStimulus(4'd1, 4'd1, 4'd1, 4'd1, 1'b0);
    tick();
    checkOutput("indep_pre_e1", 32'(e1), 32'd1);
    checkOutput("indep_pre_f1", 32'(f1), 32'd1);
    applyStimulus(4'd1, 4'd1, 4'd0, 4'd1, 1'b0);
    #1;
    checkOutput("between_edges_f1", 32'(f1), 32'd1);
    tick();
    checkOutput("indep_post_f1", 32'(f1), 32'd0);
    checkOutput("indep_post_e1", 32'(e1), 32'd1);

    // Pull reset mid-cycle; outputs must clear before the next rising edge.
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_e1", 32'(e1), 32'd0);
    checkOutput("async_reset_f1", 32'(f1), 32'd0);
    checkOutput("async_reset_e4", 32'(e4), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    applyStimulus(4'd15, 4'd15, 4'd0, 4'd9, 1'b1);
    tick();
    checkOutput("wide_max_e4", 32'(e4), 32'd225);
    checkOutput("wide_zero_f4", 32'(f4), 32'd0);
    applyStimulus(4'd15, 4'd15, 4'd12, 4'd11, 1'b1);
    tick();
    checkOutput("wide_f4_132", 32'(f4), 32'd132);
    checkOutput("wide_hold_e4", 32'(e4), 32'd225);

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        applyStimulus(4'(x), 4'(y), 4'(15 - x), 4'(y), 1'b1);
        tick();
        checkOutput($sformatf("sweep_e4_%0d_%0d", x, y), 32'(e4), 32'(x * y));
        checkOutput($sformatf("sweep_f4_%0d_%0d", x, y), 32'(f4),
                    32'((15 - x) * y));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
